// File: rtl/pipeline_stage_skid.sv
// Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Provides synchronous flush (bubble insertion) and a saturating stall-cycle counter.
module pipeline_stage_skid #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]             state, state_nxt;
  logic [DATA_W-1:0]      main_data, main_data_nxt;
  logic [CTRL_W-1:0]      main_ctrl, main_ctrl_nxt;
  logic [DATA_W-1:0]      skid_data, skid_data_nxt;
  logic [CTRL_W-1:0]      skid_ctrl, skid_ctrl_nxt;
  logic [STALL_CNT_W-1:0] stall_q, stall_nxt;
  logic                   acc, deq;

  // Ready is a pure decode of registered state; reset forces it low.
  assign in_ready  = ~rst & (state != S_FULL);
  assign out_valid = (state != S_EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = state;
  assign stall_cnt = stall_q;

  assign acc = in_valid & in_ready;
  assign deq = out_valid & out_ready;

  // Next-state and holding-register update.
  always_comb begin
    state_nxt     = state;
    main_data_nxt = main_data;
    main_ctrl_nxt = main_ctrl;
    skid_data_nxt = skid_data;
    skid_ctrl_nxt = skid_ctrl;
    if (flush) begin
      state_nxt     = S_EMPTY;
      main_ctrl_nxt = '0;
      skid_ctrl_nxt = '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (acc) begin
            state_nxt     = S_ONE;
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
          end
        end
        S_ONE: begin
          if (acc && !deq) begin
            state_nxt     = S_FULL;
            skid_data_nxt = in_data;
            skid_ctrl_nxt = in_ctrl;
          end else if (acc && deq) begin
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
          end else if (deq) begin
            state_nxt     = S_EMPTY;
            main_ctrl_nxt = '0;
          end
        end
        S_FULL: begin
          if (deq) begin
            state_nxt     = S_ONE;
            main_data_nxt = skid_data;
            main_ctrl_nxt = skid_ctrl;
            skid_ctrl_nxt = '0;
          end
        end
        default: begin
          state_nxt     = S_EMPTY;
          main_ctrl_nxt = '0;
          skid_ctrl_nxt = '0;
        end
      endcase
    end
  end

  // Stall counter saturates at all-ones; flush leaves it alone.
  always_comb begin
    stall_nxt = stall_q;
    if (out_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_nxt = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      stall_q   <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_data_nxt;
      main_ctrl <= main_ctrl_nxt;
      skid_data <= skid_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
      stall_q   <= stall_nxt;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Randomized and directed bench for pipeline_stage_skid against a queue-based reference model.
module tb_pipeline_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic [3:0]  s_in_ctrl;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_data;
  logic [3:0]  s_out_ctrl;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [39:0] q[$];
  int          stall_m = 0;

  always #5 clk = ~clk;

  pipeline_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipeline_stage_skid #(.DATA_W(8), .CTRL_W(4), .STALL_CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [39:0] h;
    check("valid", 64'(out_valid), 64'(q.size() > 0));
    check("occ", 64'(occupancy), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("stall", 64'(stall_cnt), 64'(stall_m));
    if (q.size() > 0) begin
      h = q[0];
      check("data", 64'(out_data), 64'(h[31:0]));
      check("ctrl", 64'(out_ctrl), 64'(h[39:32]));
    end else begin
      check("ctrl_bubble", 64'(out_ctrl), 64'(0));
    end
  endtask

  // One clock: drive inputs, advance the model by the handshake rules, compare at negedge.
  task automatic step(input logic iv, input logic [31:0] d, input logic [7:0] c,
                      input logic ordy, input logic fl);
    bit m_acc, m_deq;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    m_acc = iv && (q.size() < 2);
    m_deq = (q.size() > 0) && ordy;
    if ((q.size() > 0) && !ordy && (stall_m < 65535)) stall_m++;
    @(posedge clk);
    if (m_deq) void'(q.pop_front());
    if (fl) q.delete();
    else if (m_acc) q.push_back({c, d});
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    q.delete();
    stall_m = 0;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_ctrl", 64'(out_ctrl), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_stall", 64'(stall_cnt), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = 8'h5A; s_in_ctrl = 4'h3; s_out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check_outputs();

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), 8'(i + 16), 1'b1, 1'b0);
      check("stream_data", 64'(out_data), 64'(i));
      check("stream_occ", 64'(occupancy), 64'(1));
    end
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    check("stream_drained", 64'(out_valid), 64'(0));

    // Back-pressure into the skid register.
    @(negedge clk);
    do_reset();
    step(1'b1, 32'h11, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 32'h22, 8'hA2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h99, 8'hFF, 1'b0, 1'b0);
      check("bp_hold_data", 64'(out_data), 64'h11);
    end
    check("bp_occ", 64'(occupancy), 64'(2));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_stall5", 64'(stall_cnt), 64'(5));
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    check("bp_second", 64'(out_data), 64'h22);
    check("bp_second_ctrl", 64'(out_ctrl), 64'hA2);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    check("bp_empty", 64'(out_valid), 64'(0));

    // Flush from FULL with a simultaneous input that must be dropped.
    step(1'b1, 32'h55, 8'h01, 1'b0, 1'b0);
    step(1'b1, 32'h66, 8'h02, 1'b0, 1'b0);
    step(1'b1, 32'h33, 8'h03, 1'b0, 1'b1);
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ctrl", 64'(out_ctrl), 64'(0));
    check("flush_occ", 64'(occupancy), 64'(0));
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    check("flush_no_c", 64'(out_valid), 64'(0));

    // Flush together with a dequeue from ONE.
    step(1'b1, 32'h44, 8'h04, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b1);
    check("flush_deq_occ", 64'(occupancy), 64'(0));

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), $urandom(), 8'($urandom()),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset in the middle of held traffic.
    step(1'b1, 32'h77, 8'h07, 1'b0, 1'b0);
    step(1'b1, 32'h88, 8'h08, 1'b0, 1'b0);
    #2;
    do_reset();
    step(1'b1, 32'hAB, 8'h0B, 1'b1, 1'b0);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

    // Saturation on the narrow-counter instance.
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    check("sat_occ", 64'(s_occupancy), 64'(1));
    check("sat_data", 64'(s_out_data), 64'h5A);
    check("sat_stall", 64'(s_stall_cnt), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
